// File: rtl/juego_pkg.sv
// Shared types for the player-side move selector of the game FSM.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package juego_pkg;

  localparam int CELL_W  = 3;
  localparam int N_CELLS = 8;

  typedef enum logic [1:0] {IDLE, SELECT, ISSUE, WAIT_ACK} sel_state_t;

  typedef logic [CELL_W-1:0] cell_t;

endpackage

// File: rtl/btn_debounce.sv
// Debounces one raw button and emits a single-cycle press pulse once it has been high HOLD_CYCLES cycles.
// Latency: pulse is registered on the edge where the hold count reaches HOLD_CYCLES.
// Backpressure: none; one pulse per press, a new pulse requires the button to be released first.
module btn_debounce #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic pulse
);

  localparam int CW = $clog2(HOLD_CYCLES + 1);

  logic [CW-1:0] cnt;

  // Count consecutive high cycles, saturate at HOLD_CYCLES so the pulse cannot repeat until release.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      pulse <= raw && (cnt == CW'(HOLD_CYCLES - 1));
      if (!raw) begin
        cnt <= '0;
      end else if (cnt != CW'(HOLD_CYCLES)) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/move_selector.sv
// Turns next/confirm buttons into a legal 3-bit cell code for the game FSM; optional auto-move via MOVE_SELECTOR_AUTO_MOVE_EN.
// Latency: confirm pulse to move_valid is 2 cycles; move_ack to move_valid low is 1 cycle.
// Backpressure: move_code/move_valid held stable until move_ack, retracted if turn drops first.
module move_selector
  import juego_pkg::*;
#(
  parameter int CELLS       = N_CELLS,
  parameter int HOLD_CYCLES = 4
`ifdef MOVE_SELECTOR_AUTO_MOVE_EN
  ,
  parameter int TIMEOUT_CYCLES = 64
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             turn,
  input  logic [CELLS-1:0] occupied,
  input  logic             btn_next,
  input  logic             btn_confirm,
  input  logic             move_ack,
  output cell_t            cursor,
  output cell_t            move_code,
  output logic             move_valid,
  output logic             no_move
`ifdef MOVE_SELECTOR_AUTO_MOVE_EN
  ,
  output logic             auto_flag
`endif
);

  sel_state_t state;
  logic       next_p;
  logic       confirm_p;
  logic       all_full;
  cell_t      free_here;
  cell_t      free_after;

  // Lowest free cell at or above start, wrapping; returns start when nothing is free.
  function automatic cell_t first_free(input cell_t start, input logic [CELLS-1:0] occ);
    cell_t idx;
    cell_t res;
    logic  hit;
    res = start;
    hit = 1'b0;
    for (int i = 0; i < CELLS; i++) begin
      idx = start + cell_t'(i);
      if (!hit && !occ[idx]) begin
        res = idx;
        hit = 1'b1;
      end
    end
    return res;
  endfunction

  btn_debounce #(.HOLD_CYCLES(HOLD_CYCLES)) u_db_next (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_next),
    .pulse (next_p)
  );

  btn_debounce #(.HOLD_CYCLES(HOLD_CYCLES)) u_db_confirm (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_confirm),
    .pulse (confirm_p)
  );

  assign all_full   = &occupied;
  assign free_here  = first_free(cursor, occupied);
  assign free_after = first_free(cursor + cell_t'(1), occupied);

`ifdef MOVE_SELECTOR_AUTO_MOVE_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt;
  logic          timeout;
  assign timeout = (tcnt == TW'(TIMEOUT_CYCLES - 1));
`endif

  // Selection FSM with all outputs registered; confirm outranks next when both pulse together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cursor     <= '0;
      move_code  <= '0;
      move_valid <= 1'b0;
      no_move    <= 1'b0;
`ifdef MOVE_SELECTOR_AUTO_MOVE_EN
      tcnt       <= '0;
      auto_flag  <= 1'b0;
`endif
    end else begin
`ifdef MOVE_SELECTOR_AUTO_MOVE_EN
      tcnt      <= '0;
      auto_flag <= 1'b0;
`endif
      case (state)
        IDLE: begin
          move_valid <= 1'b0;
          if (turn && all_full) begin
            no_move <= 1'b1;
          end else begin
            no_move <= 1'b0;
            if (turn) begin
              cursor <= free_here;
              state  <= SELECT;
            end
          end
        end
        SELECT: begin
          if (!turn) begin
            state <= IDLE;
          end else if (confirm_p) begin
            // A cell taken since it was highlighted cannot be committed.
            if (!occupied[cursor]) begin
              move_code <= cursor;
              state     <= ISSUE;
            end
          end else if (next_p) begin
            cursor <= free_after;
          end
`ifdef MOVE_SELECTOR_AUTO_MOVE_EN
          else if (timeout && !all_full) begin
            cursor    <= free_here;
            move_code <= free_here;
            auto_flag <= 1'b1;
            state     <= ISSUE;
          end
          if (turn && !confirm_p && !next_p) begin
            tcnt <= tcnt + TW'(1);
          end
`endif
        end
        ISSUE: begin
          move_valid <= 1'b1;
          state      <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (move_ack || !turn) begin
            move_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          state      <= IDLE;
          move_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
